// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE peripheral control initiator:
// register byte offsets, the offloader state encoding and an address helper.
package hwpe_ctrl_package;

    localparam logic [31:0] TRIGGER_OFFS   = 32'h00;
    localparam logic [31:0] ACQUIRE_OFFS   = 32'h04;
    localparam logic [31:0] SOFTCLEAR_OFFS = 32'h14;
    localparam logic [31:0] JOB_BASE_OFFS  = 32'h20;

    typedef enum logic [2:0] {
        OFFLOAD_IDLE,
        OFFLOAD_ACQ,
        OFFLOAD_ACQ_WAIT,
        OFFLOAD_BACKOFF,
        OFFLOAD_PROG,
        OFFLOAD_TRIG,
        OFFLOAD_WAIT_EVT,
        OFFLOAD_CLEAR
    } offload_state_t;

    // Byte address of job register k relative to a given control base
    function automatic logic [31:0] job_reg_addr(input logic [31:0] base, input logic [31:0] k);
        return base + JOB_BASE_OFFS + (k << 2);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// HWPE peripheral control port: single request channel with grant and a
// tagged response channel (r_id echoes the requester id).
interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = 8
);
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hwpe_ctrl_offload_timer.sv
// Loadable down-counter used as the completion watchdog of the offloader.
// Only compiled when HWPE_CTRL_OFFLOADER_TIMEOUT_EN is defined.
`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
module hwpe_ctrl_offload_timer #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires in the cycle that is the load_val-th enabled cycle after loading
    assign expired_o = en_i && (cnt_q == CNT_W'(1));

endmodule
`endif

// File: rtl/hwpe_ctrl_offloader.sv
// HWPE control initiator: acquire a context, program job registers,
// trigger, then wait for the completion event.
// Optional completion watchdog with softclear: HWPE_CTRL_OFFLOADER_TIMEOUT_EN.
module hwpe_ctrl_offloader
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_JOB_REGS     = 8,
    parameter int unsigned ID_WIDTH       = 16,
    parameter int unsigned CORE_ID        = 0,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned RETRY_WAIT     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    hwpe_ctrl_intf_periph.master                  cfg,
    input  logic                                  job_valid_i,
    output logic                                  job_ready_o,
    input  logic [$clog2(N_JOB_REGS+1)-1:0]       job_nregs_i,
    input  logic [N_JOB_REGS*32-1:0]              job_regs_i,
    input  logic                                  evt_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [7:0]                            done_id_o,
    output logic                                  error_o
);

    localparam int unsigned NREG_W = $clog2(N_JOB_REGS + 1);
    localparam int unsigned IDX_W  = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam int unsigned BO_W   = $clog2(RETRY_WAIT + 1);
    localparam logic [ID_WIDTH-1:0] CORE_ONEHOT = ID_WIDTH'(1) << CORE_ID;

    offload_state_t      state_q, state_d;
    logic                req_q, req_d;
    logic [31:0]         add_q, add_d;
    logic                wen_q, wen_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         data_q, data_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          done_id_q, done_id_d;
    logic [7:0]          job_id_q, job_id_d;
    logic [NREG_W-1:0]   nregs_q, nregs_d;
    logic [NREG_W-1:0]   k_q, k_d;
    logic [BO_W-1:0]     bo_cnt_q, bo_cnt_d;
    logic [31:0]         regs_q [N_JOB_REGS];
    logic                accept;
    logic                rsp_hit;
    logic [NREG_W-1:0]   k_next;

    // Descriptors asking for more registers than exist are cut to the maximum
    function automatic logic [NREG_W-1:0] clamp_nregs(input logic [NREG_W-1:0] n);
        return (n > NREG_W'(N_JOB_REGS)) ? NREG_W'(N_JOB_REGS) : n;
    endfunction

`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic error_q, error_d;
    logic tmo_load, tmo_en, tmo_expired;

    assign tmo_load = (state_q == OFFLOAD_TRIG) && cfg.gnt;
    assign tmo_en   = (state_q == OFFLOAD_WAIT_EVT);

    hwpe_ctrl_offload_timer #(
        .CNT_W (TMO_W)
    ) i_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmo_load),
        .load_val_i (TMO_W'(TIMEOUT_CYCLES)),
        .en_i       (tmo_en),
        .expired_o  (tmo_expired)
    );

    assign error_o = error_q;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign error_o = 1'b0;
`endif

    assign job_ready_o = (state_q == OFFLOAD_IDLE) && !rst_i;
    assign accept      = job_valid_i && job_ready_o;
    assign rsp_hit     = cfg.r_valid && (cfg.r_id == id_q);
    assign k_next      = k_q + NREG_W'(1);

    // Next-state and next-request computation for the offload sequence
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        add_d     = add_q;
        wen_d     = wen_q;
        be_d      = be_q;
        data_d    = data_q;
        id_d      = id_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        job_id_d  = job_id_q;
        nregs_d   = nregs_q;
        k_d       = k_q;
        bo_cnt_d  = bo_cnt_q;
`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
        error_d   = 1'b0;
`endif
        unique case (state_q)
            OFFLOAD_IDLE: begin
                if (accept) begin
                    nregs_d = clamp_nregs(job_nregs_i);
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = OFFLOAD_ACQ;
                    req_d   = 1'b1;
                    add_d   = BASE_ADDR + ACQUIRE_OFFS;
                    wen_d   = 1'b1;
                    be_d    = 4'hF;
                    data_d  = '0;
                    id_d    = CORE_ONEHOT;
                end
            end
            OFFLOAD_ACQ: begin
                if (cfg.gnt) begin
                    req_d   = 1'b0;
                    state_d = OFFLOAD_ACQ_WAIT;
                end
            end
            OFFLOAD_ACQ_WAIT: begin
                if (rsp_hit) begin
                    if (cfg.r_data[31]) begin
                        state_d  = OFFLOAD_BACKOFF;
                        bo_cnt_d = BO_W'(RETRY_WAIT - 1);
                    end else begin
                        job_id_d = cfg.r_data[7:0];
                        req_d    = 1'b1;
                        wen_d    = 1'b0;
                        be_d     = 4'hF;
                        if (nregs_q != '0) begin
                            state_d = OFFLOAD_PROG;
                            add_d   = job_reg_addr(BASE_ADDR, 32'd0);
                            data_d  = regs_q[0];
                        end else begin
                            state_d = OFFLOAD_TRIG;
                            add_d   = BASE_ADDR + TRIGGER_OFFS;
                            data_d  = '0;
                        end
                    end
                end
            end
            OFFLOAD_BACKOFF: begin
                if (bo_cnt_q == '0) begin
                    state_d = OFFLOAD_ACQ;
                    req_d   = 1'b1;
                    add_d   = BASE_ADDR + ACQUIRE_OFFS;
                    wen_d   = 1'b1;
                    be_d    = 4'hF;
                    data_d  = '0;
                end else begin
                    bo_cnt_d = bo_cnt_q - BO_W'(1);
                end
            end
            OFFLOAD_PROG: begin
                // Address/data only move on grant, so a stalled write is held
                if (cfg.gnt) begin
                    if (k_next == nregs_q) begin
                        state_d = OFFLOAD_TRIG;
                        add_d   = BASE_ADDR + TRIGGER_OFFS;
                        data_d  = '0;
                    end else begin
                        k_d    = k_next;
                        add_d  = job_reg_addr(BASE_ADDR, 32'(k_next));
                        data_d = regs_q[IDX_W'(k_next)];
                    end
                end
            end
            OFFLOAD_TRIG: begin
                if (cfg.gnt) begin
                    req_d   = 1'b0;
                    state_d = OFFLOAD_WAIT_EVT;
                end
            end
            OFFLOAD_WAIT_EVT: begin
                if (evt_i) begin
                    state_d   = OFFLOAD_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = job_id_q;
                end
`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_d = OFFLOAD_CLEAR;
                    req_d   = 1'b1;
                    add_d   = BASE_ADDR + SOFTCLEAR_OFFS;
                    wen_d   = 1'b0;
                    be_d    = 4'hF;
                    data_d  = '0;
                end
`endif
            end
`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
            OFFLOAD_CLEAR: begin
                if (cfg.gnt) begin
                    req_d   = 1'b0;
                    state_d = OFFLOAD_IDLE;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = OFFLOAD_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= OFFLOAD_IDLE;
            req_q     <= 1'b0;
            add_q     <= '0;
            wen_q     <= 1'b1;
            be_q      <= '0;
            data_q    <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            job_id_q  <= '0;
            nregs_q   <= '0;
            k_q       <= '0;
            bo_cnt_q  <= '0;
`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            add_q     <= add_d;
            wen_q     <= wen_d;
            be_q      <= be_d;
            data_q    <= data_d;
            id_q      <= id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            job_id_q  <= job_id_d;
            nregs_q   <= nregs_d;
            k_q       <= k_d;
            bo_cnt_q  <= bo_cnt_d;
`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
            error_q   <= error_d;
`endif
        end
    end

    // Descriptor register values, captured on accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < N_JOB_REGS; i++) begin
                regs_q[i] <= job_regs_i[i*32 +: 32];
            end
        end
    end

    assign cfg.req   = req_q;
    assign cfg.add   = add_q;
    assign cfg.wen   = wen_q;
    assign cfg.be    = be_q;
    assign cfg.data  = data_q;
    assign cfg.id    = id_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;

endmodule

// File: tb/tb_hwpe_ctrl_offloader.sv
// Scoreboard bench for hwpe_ctrl_offloader: expected requests and completions
// are queued by the stimulus process and consumed by independent monitors.
module tb_hwpe_ctrl_offloader;

    localparam int NR  = 8;
    localparam int RW  = 4;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           job_valid = 1'b0;
    logic           job_ready;
    logic [3:0]     job_nregs = '0;
    logic [NR*32-1:0] job_regs = '0;
    logic           evt;
    logic           busy, done, error;
    logic [7:0]     done_id;

    always #5 clk = ~clk;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(16)) cfg_if ();

    hwpe_ctrl_offloader #(
        .N_JOB_REGS     (NR),
        .ID_WIDTH       (16),
        .CORE_ID        (0),
        .BASE_ADDR      (32'h0),
        .RETRY_WAIT     (RW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg         (cfg_if),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .job_nregs_i (job_nregs),
        .job_regs_i  (job_regs),
        .evt_i       (evt),
        .busy_o      (busy),
        .done_o      (done),
        .done_id_o   (done_id),
        .error_o     (error)
    );

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
        int          at;
    } req_t;

    req_t        exp_req_q [$];
    logic [7:0]  exp_done_q [$];
    logic [31:0] acq_q [$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int evt_at = -1;
    int evt_dly = 0;
    int stray_evt_at = -1;
    int stray_rv_at = -1;
    logic [31:0] stall_addr = 32'hFFFF_FFF0;
    int stall_target = 0;
    int stall_done = 0;

    logic        rv_q = 1'b0;
    logic [31:0] rdata_q = '0;
    logic [15:0] rid_q = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: grant unless a stall is armed, answer every granted request
    assign cfg_if.gnt = !(cfg_if.req && (cfg_if.add == stall_addr) && (stall_done < stall_target));
    assign cfg_if.r_valid = rv_q || (cyc == stray_rv_at);
    assign cfg_if.r_data  = (cyc == stray_rv_at) ? 32'h7 : rdata_q;
    assign cfg_if.r_id    = (cyc == stray_rv_at) ? 16'h1 : rid_q;
    assign evt = (cyc == evt_at) || (cyc == stray_evt_at);

    always @(posedge clk) begin
        if (cfg_if.req && (cfg_if.add == stall_addr) && (stall_done < stall_target))
            stall_done <= stall_done + 1;
    end

    always @(posedge clk) begin
        rv_q <= 1'b0;
        if (cfg_if.req && cfg_if.gnt) begin
            rv_q  <= 1'b1;
            rid_q <= cfg_if.id;
            if (cfg_if.wen) rdata_q <= (acq_q.size() > 0) ? acq_q.pop_front() : 32'h8000_0000;
            else            rdata_q <= 32'hFFFF_FFFF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request monitor: every granted request must match the head of the queue
    initial begin : req_mon
        logic p_req, p_gnt;
        logic [31:0] p_add, p_data;
        req_t e;
        bit ok;
        p_req = 1'b0; p_gnt = 1'b1; p_add = '0; p_data = '0;
        forever begin
            @(negedge clk);
            if (p_req && !p_gnt) begin
                n_cmp++;
                if (!(cfg_if.req && cfg_if.add == p_add && cfg_if.data == p_data)) begin
                    n_fail++;
                    $display("FAIL hold: req=%0b add=%h data=%h, expected req=1 add=%h data=%h (cycle %0d)",
                             cfg_if.req, cfg_if.add, cfg_if.data, p_add, p_data, cyc);
                end
            end
            if (cfg_if.req && cfg_if.gnt) begin
                n_cmp++;
                if (exp_req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_req: add=%h wen=%0b data=%h at cycle %0d, expected none",
                             cfg_if.add, cfg_if.wen, cfg_if.data, cyc);
                end else begin
                    e = exp_req_q.pop_front();
                    ok = (cfg_if.add == e.add) && (cfg_if.wen == e.wen) && (cfg_if.be == 4'hF) &&
                         (cfg_if.id == 16'h1) && (e.wen || cfg_if.data == e.data) &&
                         (e.at < 0 || cyc == e.at);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL req: add=%h wen=%0b be=%h id=%h data=%h cycle=%0d, expected add=%h wen=%0b be=f id=1 data=%h cycle=%0d",
                                 cfg_if.add, cfg_if.wen, cfg_if.be, cfg_if.id, cfg_if.data, cyc,
                                 e.add, e.wen, e.data, e.at);
                    end
                    if (!e.wen && e.add == 32'h00 && evt_dly >= 0) evt_at = cyc + evt_dly;
                end
            end
            p_req = cfg_if.req; p_gnt = cfg_if.gnt; p_add = cfg_if.add; p_data = cfg_if.data;
        end
    end

    // Completion monitor
    initial begin : done_mon
        logic [7:0] ed;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: id=%h at cycle %0d, expected none", done_id, cyc);
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done_id", 32'(done_id), 32'(ed));
                    check("done_cycle", cyc, evt_at + 1);
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("error_at_done", 32'(error), 32'd0);
                end
            end
        end
    end

    task automatic start_job(input int n, input logic [31:0] regs [8], input int n_retry,
                             input int dly, input logic [7:0] exp_id, input bit timed,
                             input bit abort, output int t);
        int eff, base, nw;
        eff = (n > NR) ? NR : n;
        evt_dly = dly;
        @(negedge clk);
        job_valid = 1'b1;
        job_nregs = 4'(n);
        for (int k = 0; k < NR; k++) job_regs[k*32 +: 32] = regs[k];
        #1;
        for (int w = 0; w < 50 && !job_ready; w++) begin
            @(negedge clk); #1;
        end
        if (!job_ready) begin
            $display("FAIL job_accept: job_ready=0 after 50 cycles, expected 1");
            $fatal(1, "aborting: descriptor never accepted");
        end
        t = cyc;
        for (int r = 0; r <= n_retry; r++)
            exp_req_q.push_back('{32'h04, 1'b1, 32'h0, timed ? t + 1 + r * (RW + 2) : -1});
        base = t + 3 + n_retry * (RW + 2);
        nw = abort ? ((eff < 2) ? eff : 2) : eff;
        for (int k = 0; k < nw; k++)
            exp_req_q.push_back('{32'h20 + 32'(4 * k), 1'b0, regs[k], timed ? base + k : -1});
        if (!abort) begin
            exp_req_q.push_back('{32'h00, 1'b0, 32'h0, timed ? base + eff : -1});
            if (dly >= 0) exp_done_q.push_back(exp_id);
        end
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int w = 0; w < 400 && (exp_done_q.size() != 0 || exp_req_q.size() != 0); w++)
            @(negedge clk);
        if (exp_done_q.size() != 0 || exp_req_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: %0d requests and %0d completions still pending, expected 0",
                     name, exp_req_q.size(), exp_done_q.size());
        end
        @(negedge clk);
    endtask

    initial begin : main
        logic [31:0] r [8];
        int t;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", 32'(cfg_if.req), 32'd0);
        check("rst_add", cfg_if.add, 32'd0);
        check("rst_wen", 32'(cfg_if.wen), 32'd1);
        check("rst_be", 32'(cfg_if.be), 32'd0);
        check("rst_data", cfg_if.data, 32'd0);
        check("rst_id", 32'(cfg_if.id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_job_ready", 32'(job_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Three registers, acquire id 5, event 10 cycles after trigger, stale event in ACQ_WAIT
        r = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 0, 0, 0, 0, 0};
        acq_q.push_back(32'h5);
        start_job(3, r, 0, 10, 8'h05, 1'b1, 1'b0, t);
        #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        stray_evt_at = cyc + 1;
        wait_idle("job_basic");

        // Two full-context retries then id 2
        r = '{32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0, 0, 0};
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'h2);
        start_job(2, r, 2, 3, 8'h02, 1'b1, 1'b0, t);
        wait_idle("job_retry");

        // Grant withheld for 3 cycles on write k=1
        stall_addr = 32'h24;
        stall_target = stall_done + 3;
        r = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 0, 0, 0, 0, 0};
        acq_q.push_back(32'h11);
        start_job(3, r, 0, 2, 8'h11, 1'b0, 1'b0, t);
        wait_idle("job_stall");
        check("stall_cycles", stall_done, stall_target);
        stall_addr = 32'hFFFF_FFF0;

        // No registers: acquire then straight to trigger, earliest event
        acq_q.push_back(32'h30);
        start_job(0, r, 0, 1, 8'h30, 1'b1, 1'b0, t);
        wait_idle("job_zero");

        // nregs 15 clamps to 8; only the low byte of the acquire is the id
        r = '{32'h80, 32'h81, 32'h82, 32'h83, 32'h84, 32'h85, 32'h86, 32'h87};
        acq_q.push_back(32'h1A5);
        start_job(15, r, 0, 4, 8'hA5, 1'b1, 1'b0, t);
        wait_idle("job_clamp");

        // Reset during PROG, then a late response while idle, then a clean job
        r = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 0, 0, 0};
        acq_q.push_back(32'h3);
        start_job(4, r, 0, -1, 8'h00, 1'b1, 1'b1, t);
        while (cyc < t + 4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("job_ready_in_rst", 32'(job_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_after_rst", 32'(cfg_if.req), 32'd0);
        check("busy_after_rst", 32'(busy), 32'd0);
        check("job_ready_after_rst", 32'(job_ready), 32'd1);
        stray_rv_at = cyc + 1;
        repeat (3) @(negedge clk);
        #1;
        check("req_idle_after_stray_rv", 32'(cfg_if.req), 32'd0);
        check("busy_idle_after_stray_rv", 32'(busy), 32'd0);
        check("pending_after_rst", exp_req_q.size(), 32'd0);
        r = '{32'h5151_5151, 0, 0, 0, 0, 0, 0, 0};
        acq_q.push_back(32'h9);
        start_job(1, r, 0, 5, 8'h09, 1'b1, 1'b0, t);
        wait_idle("job_after_rst");

`ifdef HWPE_CTRL_OFFLOADER_TIMEOUT_EN
        // Event never arrives: softclear write, then error pulse, no done
        begin
            int trig;
            r = '{32'h7777_0000, 0, 0, 0, 0, 0, 0, 0};
            acq_q.push_back(32'h4);
            start_job(1, r, 0, -1, 8'h00, 1'b1, 1'b0, t);
            trig = t + 4;
            exp_req_q.push_back('{32'h14, 1'b0, 32'h0, trig + TMO + 1});
            for (int w = 0; w < 200 && !error; w++) @(negedge clk);
            check("error_seen", 32'(error), 32'd1);
            check("error_cycle", cyc, trig + TMO + 2);
            check("done_at_error", 32'(done), 32'd0);
            check("busy_at_error", 32'(busy), 32'd0);
            @(negedge clk);
            check("error_one_cycle", 32'(error), 32'd0);
            check("job_ready_after_error", 32'(job_ready), 32'd1);
        end
`endif

        repeat (5) @(negedge clk);
        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("acq_queue_empty", acq_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
